uart_comm: RTL and testbench
============================

UART_COMM -- requirements
Module: uart_comm

Interface
REQ-001 Parameter BAUD_DIV, default 2604: clocks per UART bit (8N1), minimum 8.
REQ-002 Parameter FRAME_TO, default 16: idle bit-times between bytes after which a partial command is abandoned.
REQ-003 clk  in  1  system clock; one clock; all state on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 RX  in  1  serial input from host; asynchronous; idles high.
REQ-006 TX  out  1  serial output to host; idles high.
REQ-007 cmd  out  24  assembled command; byte 1 in [23:16], byte 2 in [15:8], byte 3 in [7:0].
REQ-008 cmd_rdy  out  1  high while cmd holds a complete, unconsumed command.
REQ-009 clr_cmd_rdy  in  1  single-clock pulse from the command decoder; clears cmd_rdy.
REQ-010 resp_data  in  8  response byte to transmit.
REQ-011 send_resp  in  1  single-clock pulse; starts transmission of resp_data.
REQ-012 resp_sent  out  1  single-clock pulse when the response stop bit completes.

Function
REQ-013 RX shall pass through a two-flop synchronizer preset to 1 before any use.
REQ-014 Receiver FSM states: IDLE, START, DATA, STOP.
REQ-015 IDLE->START on a synchronized high-to-low transition of RX; the bit counter is loaded with BAUD_DIV/2.
REQ-016 START: sample at mid-bit; if RX is 1, it is a false start and the FSM returns to IDLE with no byte produced; if RX is 0, go to DATA.
REQ-017 DATA: sample 8 bits LSB first, each BAUD_DIV clocks after the previous sample; then go to STOP.
REQ-018 STOP: sample at mid stop bit; if 1, the byte is accepted; if 0 (framing error), the byte is discarded and the byte index is reset to 0; in both cases return to IDLE.
REQ-019 Accepted bytes fill cmd in order using a 2-bit byte index (0, 1, 2); cmd bits not yet written keep their prior value.
REQ-020 On acceptance of byte index 2: cmd_rdy is set on the next clock, and the index returns to 0.
REQ-021 Latency: cmd[7:0] and cmd_rdy are valid 1 clock after the third stop-bit sample.
REQ-022 While cmd_rdy=1, accepted bytes are discarded; cmd shall not change and the index shall not advance.
REQ-023 clr_cmd_rdy clears cmd_rdy on the next clock. If set and clear occur in the same cycle, set wins.
REQ-024 With the index nonzero, if more than FRAME_TO bit-times elapse with the receiver in IDLE, the index resets to 0.
REQ-025 Transmitter FSM states: TX_IDLE, TX_SHIFT.
REQ-026 send_resp in TX_IDLE loads {1, resp_data, 0} into a 10-bit shift register; TX drives the start bit on the next clock.
REQ-027 Each bit is held for exactly BAUD_DIV clocks, LSB first, followed by the stop bit.
REQ-028 resp_sent pulses for 1 clock after the stop bit's BAUD_DIV clocks, which is 10*BAUD_DIV+1 clocks after send_resp; the transmitter then returns to TX_IDLE.
REQ-029 send_resp while in TX_SHIFT is ignored.
REQ-030 send_resp on the same clock as resp_sent is accepted as a new transmission.
REQ-031 The receiver and transmitter operate independently (full duplex).

Reset
REQ-032 rst_n low asynchronously forces: both FSMs idle, TX=1, cmd=24'h000000, cmd_rdy=0, resp_sent=0, byte index=0, and all counters=0.
REQ-033 Reset asserted mid-byte or mid-transmit aborts the operation; no partial byte or resp_sent pulse survives.

Structure
REQ-034 A shared package holds: the receiver state typedef, the transmitter state typedef, and the bits-per-frame constant (10).
REQ-035 The transmitter is a sub-module, uart_tx; the receiver and command assembly stay in uart_comm.

Verification
REQ-036 BAUD_DIV=16; host sends 0x02, 0x0D, 0x5A -> cmd=24'h020D5A and cmd_rdy=1 exactly 1 clock after the third stop-bit sample.
REQ-037 cmd_rdy=1, then a further 3 bytes 0x08/0x11/0x22 are sent -> cmd unchanged; after a clr_cmd_rdy pulse, cmd_rdy=0 on the next clock.
REQ-038 RX low glitch of 4 clocks -> no byte; then byte 0x55 with stop bit 0 -> discarded and index=0; next 3 good bytes 0x07/0x00/0x00 -> cmd=24'h070000.
REQ-039 Send one byte 0x01, wait 20 bit-times, then send 0x09/0x03/0x04 -> cmd=24'h090304.
REQ-040 send_resp with resp_data=0xA5 -> TX pattern 0,1,0,1,0,0,1,0,1,1 at 16 clocks per bit; resp_sent at clock 161; a send_resp at clock 50 has no effect.
REQ-041 rst_n pulsed low mid-way through the second byte -> cmd=0, cmd_rdy=0, TX=1; the next full 3-byte command assembles correctly.

Source files
------------

// File: rtl/uart_comm_pkg.sv
// Shared types and constants for the UART command front end.
// FSM states are plain logic encodings so older tools and wave viewers see stable values.
package uart_comm_pkg;

    typedef logic [1:0] rx_state_t;
    localparam rx_state_t RX_IDLE  = 2'd0;
    localparam rx_state_t RX_START = 2'd1;
    localparam rx_state_t RX_DATA  = 2'd2;
    localparam rx_state_t RX_STOP  = 2'd3;

    typedef logic tx_state_t;
    localparam tx_state_t TX_IDLE  = 1'b0;
    localparam tx_state_t TX_SHIFT = 1'b1;

    // start + 8 data + stop
    localparam int unsigned FRAME_BITS = 10;

endpackage

// File: rtl/uart_comm_if.sv
// Command/response handshake between uart_comm (slave) and the command decoder (master).
interface uart_comm_if;

    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic        resp_sent;

    modport master (
        input  cmd, cmd_rdy, resp_sent,
        output clr_cmd_rdy, resp_data, send_resp
    );

    modport slave (
        output cmd, cmd_rdy, resp_sent,
        input  clr_cmd_rdy, resp_data, send_resp
    );

endinterface

// File: rtl/uart_tx.sv
// 8N1 transmitter: sends one response byte per send_resp, pulses resp_sent after the stop bit.
module uart_tx
    import uart_comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_resp,
    input  logic [7:0] resp_data,
    output logic       TX,
    output logic       resp_sent
);

    localparam int unsigned CW = $clog2(BAUD_DIV);

    tx_state_t             state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]         baud_q, baud_d;
    logic [3:0]            bitn_q, bitn_d;
    logic                  sent_q, sent_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bitn_d  = bitn_q;
        sent_d  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    shift_d = {1'b1, resp_data, 1'b0};
                    baud_d  = '0;
                    bitn_d  = '0;
                    state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (baud_q == CW'(BAUD_DIV - 1)) begin
                    baud_d  = '0;
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                    if (bitn_q == 4'(FRAME_BITS - 1)) begin
                        state_d = TX_IDLE;
                        sent_d  = 1'b1;
                    end else begin
                        bitn_d = bitn_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            shift_q <= '0;
            baud_q  <= '0;
            bitn_q  <= '0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bitn_q  <= bitn_d;
            sent_q  <= sent_d;
        end
    end

    assign TX        = (state_q == TX_SHIFT) ? shift_q[0] : 1'b1;
    assign resp_sent = sent_q;

endmodule

// File: rtl/uart_comm.sv
// UART command front end: assembles 3-byte host commands into cmd and hands responses
// to uart_tx. Receiver and transmitter run independently.
module uart_comm
    import uart_comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 2604,
    parameter int unsigned FRAME_TO = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    uart_comm_if.slave bus
);

    localparam int unsigned CW      = $clog2(BAUD_DIV);
    localparam int unsigned TO_CLKS = FRAME_TO * BAUD_DIV;
    localparam int unsigned IW      = $clog2(TO_CLKS + 1);

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitn_q, bitn_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    idx_q, idx_d;
    logic [23:0]   cmd_q, cmd_d;
    logic          rdy_q, rdy_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          rx_fall;
    logic          mid_bit;

    // Synchronizer presets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_sync_q;
    assign mid_bit = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bitn_d  = bitn_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        cmd_d   = cmd_q;
        rdy_d   = rdy_q;
        idle_d  = '0;
        if (bus.clr_cmd_rdy) begin
            rdy_d = 1'b0;
        end
        case (state_q)
            RX_IDLE: begin
                // Abandon a partial command once the host has been quiet too long.
                if (idx_q != 2'd0) begin
                    if (idle_q == IW'(TO_CLKS)) begin
                        idx_d = 2'd0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                if (rx_fall) begin
                    state_d = RX_START;
                    cnt_d   = CW'(BAUD_DIV / 2);
                end
            end
            RX_START: begin
                if (mid_bit) begin
                    if (rx_sync_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        cnt_d   = CW'(BAUD_DIV - 1);
                        bitn_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (mid_bit) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = CW'(BAUD_DIV - 1);
                    if (bitn_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bitn_d = bitn_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (mid_bit) begin
                    state_d = RX_IDLE;
                    if (!rx_sync_q) begin
                        idx_d = 2'd0;
                    end else if (!rdy_q) begin
                        // An unconsumed command blocks further bytes entirely.
                        case (idx_q)
                            2'd0: begin
                                cmd_d[23:16] = shift_q;
                                idx_d        = 2'd1;
                            end
                            2'd1: begin
                                cmd_d[15:8] = shift_q;
                                idx_d       = 2'd2;
                            end
                            2'd2: begin
                                cmd_d[7:0] = shift_q;
                                idx_d      = 2'd0;
                                rdy_d      = 1'b1;
                            end
                            default: idx_d = 2'd0;
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bitn_q  <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            cmd_q   <= '0;
            rdy_q   <= 1'b0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            rdy_q   <= rdy_d;
            idle_q  <= idle_d;
        end
    end

    assign bus.cmd     = cmd_q;
    assign bus.cmd_rdy = rdy_q;

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_resp (bus.send_resp),
        .resp_data (bus.resp_data),
        .TX        (TX),
        .resp_sent (bus.resp_sent)
    );

endmodule

// File: tb/tb_uart_comm.sv
// Bench for uart_comm: directed scenarios plus randomized full-duplex traffic, all checked
// every cycle against a frame-level model of command assembly and response transmission.
module tb_uart_comm;

    localparam int B      = 16;
    localparam int FTO    = 16;
    // Clocks from driving a start edge to the receiver leaving idle, plus one for the sample.
    localparam int RX_LAT = 4;

    typedef struct {
        int         v;
        int         k;
        logic [7:0] d;
        logic       ok;
    } rx_ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic RX    = 1'b1;
    logic TX;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    uart_comm_if bus ();

    uart_comm #(
        .BAUD_DIV (B),
        .FRAME_TO (FTO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (RX),
        .TX    (TX),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    rx_ev_t      evq[$];
    logic [23:0] m_cmd     = '0;
    logic        m_rdy     = 1'b0;
    int          m_idx     = 0;
    int          m_last_v  = 0;
    logic        clr_seen  = 1'b0;
    logic        tx_active = 1'b0;
    int          tx_start  = 0;
    logic [9:0]  tx_frame  = '0;
    int          rdy_rise  = -1;
    logic        rdy_prev  = 1'b0;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : model_cmp
        rx_ev_t ev;
        logic   set_now;
        logic   exp_tx;
        logic   exp_sent;
        int     off;
        set_now = 1'b0;
        if (!rst_n) begin
            m_cmd     = '0;
            m_rdy     = 1'b0;
            m_idx     = 0;
            m_last_v  = 0;
            clr_seen  = 1'b0;
            tx_active = 1'b0;
            evq.delete();
            check("rst_cmd", bus.cmd, 24'h0);
            check("rst_rdy", bus.cmd_rdy, 24'h0);
            check("rst_tx", TX, 24'h1);
            check("rst_sent", bus.resp_sent, 24'h0);
        end else begin
            if (evq.size() > 0 && evq[0].v == cyc) begin
                ev = evq.pop_front();
                if (m_idx != 0 && (ev.k - m_last_v) > FTO * B) m_idx = 0;
                if (!ev.ok) begin
                    m_idx = 0;
                end else if (!m_rdy) begin
                    m_cmd[23 - 8 * m_idx -: 8] = ev.d;
                    m_idx++;
                    if (m_idx == 3) begin
                        m_idx   = 0;
                        m_rdy   = 1'b1;
                        set_now = 1'b1;
                    end
                end
                m_last_v = ev.v;
            end
            if (clr_seen && !set_now) m_rdy = 1'b0;
            exp_tx   = 1'b1;
            exp_sent = 1'b0;
            if (tx_active) begin
                off = cyc - tx_start;
                if (off >= 1 && off <= 10 * B) exp_tx = tx_frame[(off - 1) / B];
                exp_sent = (off == 10 * B + 1);
            end
            check("cmd", bus.cmd, m_cmd);
            check("cmd_rdy", bus.cmd_rdy, m_rdy);
            check("tx", TX, exp_tx);
            check("resp_sent", bus.resp_sent, exp_sent);
            clr_seen = bus.clr_cmd_rdy;
            if (bus.send_resp && (!tx_active || cyc - tx_start >= 10 * B + 1)) begin
                tx_active = 1'b1;
                tx_start  = cyc;
                tx_frame  = {1'b1, bus.resp_data, 1'b0};
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.cmd_rdy && !rdy_prev) rdy_rise = cyc;
        rdy_prev = bus.cmd_rdy;
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic ok, output int k);
        logic [9:0] f;
        f = {ok, d, 1'b0};
        @(posedge clk);
        #1;
        k = cyc;
        evq.push_back('{v: k + 9 * B + B / 2 + RX_LAT, k: k, d: d, ok: ok});
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            wait_cycles(B);
        end
        RX = 1'b1;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1;
        bus.clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_cmd_rdy = 1'b0;
    endtask

    task automatic send_tx(input logic [7:0] d);
        @(posedge clk);
        #1;
        bus.resp_data = d;
        bus.send_resp = 1'b1;
        @(posedge clk);
        #1;
        bus.send_resp = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n           = 1'b0;
        RX              = 1'b1;
        bus.send_resp   = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        wait_cycles(3);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: bench did not finish, got cycle %0d, expected below 200000", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin : stim
        int         k;
        int         c;
        int         sent_at;
        int         sent_cnt;
        logic [9:0] pat;
        bus.clr_cmd_rdy = 1'b0;
        bus.resp_data   = 8'h00;
        bus.send_resp   = 1'b0;
        wait_cycles(3);
        check("init_cmd", bus.cmd, 24'h0);
        check("init_rdy", bus.cmd_rdy, 24'h0);
        check("init_tx", TX, 24'h1);
        rst_n = 1'b1;
        wait_cycles(4);

        // Basic command and exact ready latency
        send_byte(8'h02, 1'b1, k);
        send_byte(8'h0D, 1'b1, k);
        send_byte(8'h5A, 1'b1, k);
        check("cmd_020d5a", bus.cmd, 24'h020D5A);
        check("rdy_set", bus.cmd_rdy, 24'h1);
        check("rdy_latency", 24'(rdy_rise - k), 24'd156);

        // Bytes while ready are dropped, then clear
        send_byte(8'h08, 1'b1, k);
        send_byte(8'h11, 1'b1, k);
        send_byte(8'h22, 1'b1, k);
        check("cmd_held", bus.cmd, 24'h020D5A);
        check("rdy_held", bus.cmd_rdy, 24'h1);
        pulse_clr();
        check("rdy_cleared", bus.cmd_rdy, 24'h0);

        // Glitch, framing error, then a good command
        @(posedge clk);
        #1;
        RX = 1'b0;
        wait_cycles(4);
        RX = 1'b1;
        wait_cycles(2 * B);
        send_byte(8'h55, 1'b0, k);
        send_byte(8'h07, 1'b1, k);
        send_byte(8'h00, 1'b1, k);
        send_byte(8'h00, 1'b1, k);
        check("cmd_070000", bus.cmd, 24'h070000);
        pulse_clr();

        // Inter-byte timeout drops a partial command
        send_byte(8'h01, 1'b1, k);
        wait_cycles(20 * B);
        send_byte(8'h09, 1'b1, k);
        send_byte(8'h03, 1'b1, k);
        send_byte(8'h04, 1'b1, k);
        check("cmd_090304", bus.cmd, 24'h090304);

        // Response 0xA5: bit pattern, busy-ignore at 50, back-to-back at 161
        pat      = 10'b1101001010;
        sent_at  = -1;
        sent_cnt = 0;
        @(posedge clk);
        #1;
        c             = cyc;
        bus.resp_data = 8'hA5;
        bus.send_resp = 1'b1;
        for (int t = 1; t <= 170; t++) begin
            @(posedge clk);
            #1;
            bus.send_resp = (t == 50) || (t == 161);
            if (t == 50 || t == 161) bus.resp_data = 8'h3C;
            if (t >= 1 && t <= 160 && ((t - 1) % B) == B / 2) begin
                check("tx_bit", TX, pat[(t - 1) / B]);
            end
            if (bus.resp_sent) begin
                sent_at = t;
                sent_cnt++;
            end
            if (t == 163) check("tx_b2b_start", TX, 24'h0);
        end
        check("resp_sent_at", 24'(sent_at), 24'd161);
        check("resp_sent_cnt", 24'(sent_cnt), 24'd1);
        wait_cycles(160);

        // Reset mid second byte and mid transmit
        pulse_clr();
        send_byte(8'h11, 1'b1, k);
        @(posedge clk);
        #1;
        RX            = 1'b0;
        bus.resp_data = 8'h5C;
        bus.send_resp = 1'b1;
        @(posedge clk);
        #1;
        bus.send_resp = 1'b0;
        wait_cycles(B - 1);
        RX = 1'b1;
        wait_cycles(B);
        RX = 1'b0;
        wait_cycles(B / 2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        RX    = 1'b1;
        @(negedge clk);
        check("mid_rst_cmd", bus.cmd, 24'h0);
        check("mid_rst_rdy", bus.cmd_rdy, 24'h0);
        check("mid_rst_tx", TX, 24'h1);
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(4);
        send_byte(8'hA1, 1'b1, k);
        send_byte(8'hB2, 1'b1, k);
        send_byte(8'hC3, 1'b1, k);
        check("cmd_a1b2c3", bus.cmd, 24'hA1B2C3);
        pulse_clr();

        // Randomized full-duplex traffic
        fork
            begin : rx_rand
                int kr;
                for (int n = 0; n < 24; n++) begin
                    send_byte(8'($urandom), ($urandom_range(0, 9) != 0), kr);
                    if ($urandom_range(0, 3) == 0) begin
                        wait_cycles(B * int'($urandom_range(18, 22)));
                    end else begin
                        wait_cycles(B * int'($urandom_range(0, 3)));
                    end
                    if ($urandom_range(0, 2) == 0) pulse_clr();
                end
            end
            begin : tx_rand
                for (int n = 0; n < 10; n++) begin
                    wait_cycles(int'($urandom_range(0, 250)));
                    send_tx(8'($urandom));
                end
            end
        join
        wait_cycles(12 * B);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
